// File: rtl/controlador_contador.sv
// controlador_contador -- round-robin sequencer that shares one 4-bit multimode
// counter (00 up, 01 down, 10 down-by-3, 11 parallel load) between two
// requesters, A and B.
//
// Each accepted command drives the counter's ENB/MODO/D for exactly PASOS
// enabled cycles. The counter's Q is then captured into Q_FINAL and the owner
// gets a one-cycle DONE pulse. This block is the only driver of the counter's
// control pins.
//
// Ports:
//   CLK, RESET              clock (rising edge), async active-high reset
//   REQ_x_VALID/MODO/DATO/PASOS  command from requester x (x = A, B)
//   REQ_x_READY             combinational grant; handshake is VALID & READY
//   CNT_Q                   counter Q (input)
//   CNT_ENB/CNT_MODO/CNT_D  counter controls (registered)
//   DONE_A, DONE_B          one-cycle completion pulses
//   Q_FINAL                 counter value captured at the end of the last command
//   BUSY                    controller is not idle
//
// Optional feature, compiled in when CONTROLADOR_ABORT_EN is defined:
//   ABORT (in)              ends the running command early; the enable of the
//                           cycle in which ABORT is seen still counts
//   ABORTADO (out)          high together with DONE_x when the command was aborted

module controlador_contador #(
  parameter int PASOS_W = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               REQ_A_VALID,
  input  logic [1:0]         REQ_A_MODO,
  input  logic [3:0]         REQ_A_DATO,
  input  logic [PASOS_W-1:0] REQ_A_PASOS,
  output logic               REQ_A_READY,
  input  logic               REQ_B_VALID,
  input  logic [1:0]         REQ_B_MODO,
  input  logic [3:0]         REQ_B_DATO,
  input  logic [PASOS_W-1:0] REQ_B_PASOS,
  output logic               REQ_B_READY,
  input  logic [3:0]         CNT_Q,
  output logic               CNT_ENB,
  output logic [1:0]         CNT_MODO,
  output logic [3:0]         CNT_D,
  output logic               DONE_A,
  output logic               DONE_B,
  output logic [3:0]         Q_FINAL,
`ifdef CONTROLADOR_ABORT_EN
  input  logic               ABORT,
  output logic               ABORTADO,
`endif
  output logic               BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  state_e               state_q;
  logic                 prio_b_q;   // 1: B wins a tie, 0: A wins a tie
  logic                 owner_b_q;  // requester of the command in flight
  logic [PASOS_W-1:0]   pasos_q;    // enabled cycles still to go, including the current one
  logic                 cnt_enb_q;
  logic [1:0]           cnt_modo_q;
  logic [3:0]           cnt_d_q;
  logic                 done_a_q;
  logic                 done_b_q;
  logic [3:0]           q_final_q;

  logic                 grant_a;
  logic                 grant_b;
  logic                 accept;
  logic [1:0]           sel_modo;
  logic [3:0]           sel_dato;
  logic [PASOS_W-1:0]   sel_pasos;
  logic                 abort_w;

`ifdef CONTROLADOR_ABORT_EN
  logic                 abort_pend_q;
  logic                 abortado_q;
  assign abort_w  = ABORT;
  assign ABORTADO = abortado_q;
`else
  assign abort_w  = 1'b0;
`endif

  // Grant is only offered in IDLE. It is masked while RESET is high so that
  // READY reads low during reset.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == ST_IDLE && !RESET) begin
      if (REQ_A_VALID && (!REQ_B_VALID || !prio_b_q)) begin
        grant_a = 1'b1;
      end else if (REQ_B_VALID) begin
        grant_b = 1'b1;
      end
    end
  end

  // A grant is only given to a valid requester, so the grant itself is the handshake.
  assign accept    = grant_a | grant_b;
  assign sel_modo  = grant_b ? REQ_B_MODO  : REQ_A_MODO;
  assign sel_dato  = grant_b ? REQ_B_DATO  : REQ_A_DATO;
  assign sel_pasos = grant_b ? REQ_B_PASOS : REQ_A_PASOS;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      prio_b_q   <= 1'b0;
      owner_b_q  <= 1'b0;
      pasos_q    <= '0;
      cnt_enb_q  <= 1'b0;
      cnt_modo_q <= 2'b00;
      cnt_d_q    <= 4'd0;
      done_a_q   <= 1'b0;
      done_b_q   <= 1'b0;
      q_final_q  <= 4'd0;
`ifdef CONTROLADOR_ABORT_EN
      abort_pend_q <= 1'b0;
      abortado_q   <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
`ifdef CONTROLADOR_ABORT_EN
      abortado_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            owner_b_q <= grant_b;
            prio_b_q  <= grant_a;  // the requester just served loses the next tie
            pasos_q   <= sel_pasos;
`ifdef CONTROLADOR_ABORT_EN
            abort_pend_q <= 1'b0;
`endif
            if (sel_pasos == '0) begin
              // Zero steps: skip RUN. MODO/D keep their previous values.
              state_q <= ST_FIN;
            end else begin
              state_q    <= ST_RUN;
              cnt_enb_q  <= 1'b1;
              cnt_modo_q <= sel_modo;
              cnt_d_q    <= sel_dato;
            end
          end
        end
        ST_RUN: begin
          pasos_q <= pasos_q - 1'b1;
          // This cycle's enable is the last one: either the final step or an abort.
          if (pasos_q == PASOS_W'(1) || abort_w) begin
            cnt_enb_q <= 1'b0;
            state_q   <= ST_FIN;
`ifdef CONTROLADOR_ABORT_EN
            abort_pend_q <= ABORT;
`endif
          end
        end
        ST_FIN: begin
          // The counter took its last enabled step at the edge that entered
          // FIN, so CNT_Q already holds the final value.
          q_final_q <= CNT_Q;
          done_a_q  <= ~owner_b_q;
          done_b_q  <= owner_b_q;
`ifdef CONTROLADOR_ABORT_EN
          abortado_q <= abort_pend_q;
`endif
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign REQ_A_READY = grant_a;
  assign REQ_B_READY = grant_b;
  assign CNT_ENB     = cnt_enb_q;
  assign CNT_MODO    = cnt_modo_q;
  assign CNT_D       = cnt_d_q;
  assign DONE_A      = done_a_q;
  assign DONE_B      = done_b_q;
  assign Q_FINAL     = q_final_q;
  assign BUSY        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_controlador_contador.sv
// Bench for controlador_contador. It contains a 4-bit multimode counter for the
// controller to drive. A transaction-level reference model predicts, for every
// cycle, READY, BUSY, CNT_ENB/MODO/D, DONE and Q_FINAL. The model works from
// command arithmetic: each accepted command occupies a fixed window of cycles,
// and its final value is start + N, start - N, start - 3N or D.
module tb_controlador_contador;
  localparam int PASOS_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic a_valid, b_valid;
  logic [1:0] a_modo, b_modo;
  logic [3:0] a_dato, b_dato;
  logic [PASOS_W-1:0] a_pasos, b_pasos;
  logic a_ready, b_ready;
  logic cnt_enb;
  logic [1:0] cnt_modo;
  logic [3:0] cnt_d;
  logic done_a, done_b, busy;
  logic [3:0] q_final;
  logic [3:0] cnt_q = 4'd0;
`ifdef CONTROLADOR_ABORT_EN
  logic abort_s = 1'b0;
  logic abortado;
`endif

  controlador_contador #(.PASOS_W(PASOS_W)) dut (
    .CLK(clk), .RESET(rst),
    .REQ_A_VALID(a_valid), .REQ_A_MODO(a_modo), .REQ_A_DATO(a_dato),
    .REQ_A_PASOS(a_pasos), .REQ_A_READY(a_ready),
    .REQ_B_VALID(b_valid), .REQ_B_MODO(b_modo), .REQ_B_DATO(b_dato),
    .REQ_B_PASOS(b_pasos), .REQ_B_READY(b_ready),
    .CNT_Q(cnt_q), .CNT_ENB(cnt_enb), .CNT_MODO(cnt_modo), .CNT_D(cnt_d),
    .DONE_A(done_a), .DONE_B(done_b), .Q_FINAL(q_final),
`ifdef CONTROLADOR_ABORT_EN
    .ABORT(abort_s), .ABORTADO(abortado),
`endif
    .BUSY(busy)
  );

  // The shared counter. RESET does not clear it.
  always @(posedge clk) begin
    if (cnt_enb) begin
      case (cnt_modo)
        2'b00:   cnt_q <= cnt_q + 4'd1;
        2'b01:   cnt_q <= cnt_q - 4'd1;
        2'b10:   cnt_q <= cnt_q - 4'd3;
        default: cnt_q <= cnt_d;
      endcase
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Counter value after n enabled steps in mode m, starting from q.
  function automatic logic [3:0] apply(input logic [3:0] q, input logic [1:0] m,
                                       input logic [3:0] d, input int n);
    int t;
    case (m)
      2'b00:   t = int'(q) + n;
      2'b01:   t = int'(q) - n;
      2'b10:   t = int'(q) - 3 * n;
      default: t = (n > 0) ? int'(d) : int'(q);
    endcase
    return t[3:0];
  endfunction

  // Reference model state, indexed by cycle number.
  int cyc = 0;
  int free_at = 0;
  int done_at = -1;
  int enb_lo = 1;
  int enb_hi = 0;
  bit own_b_m = 1'b0;
  bit prio_b_m = 1'b0;
  bit abort_m = 1'b0;
  logic [3:0] model_cnt = 4'd0;
  logic [3:0] start_q = 4'd0;
  logic [3:0] pend_q = 4'd0;
  logic [3:0] qf_exp = 4'd0;
  logic [1:0] cur_m = 2'b00;
  logic [3:0] cur_d = 4'd0;
  int cur_n = 0;
  bit acc_a, acc_b;
  bit last_rdy_a;
  bit saw_abortado = 1'b0;
  int last_acc_cyc = 0;
  int last_done_cyc = 0;

  // One clock cycle: sample at the falling edge, compare against the model,
  // advance the model, then return 1 time unit after the next rising edge.
  task automatic cycle();
    bit free, era, erb, in_win;
    @(negedge clk);
    cyc++;
    free   = (cyc >= free_at);
    era    = free && a_valid && (!b_valid || !prio_b_m);
    erb    = free && b_valid && !era;
    in_win = (cyc >= enb_lo) && (cyc <= enb_hi);
    if (cyc == done_at) qf_exp = pend_q;
    check("ready_a", a_ready, era);
    check("ready_b", b_ready, erb);
    check("busy", busy, !free);
    check("cnt_enb", cnt_enb, in_win);
    check("done_a", done_a, (cyc == done_at) && !own_b_m);
    check("done_b", done_b, (cyc == done_at) && own_b_m);
    check("q_final", q_final, qf_exp);
    if (in_win) begin
      check("cnt_modo", cnt_modo, cur_m);
      check("cnt_d", cnt_d, cur_d);
    end
`ifdef CONTROLADOR_ABORT_EN
    check("abortado", abortado, (cyc == done_at) && abort_m);
    if (abortado && done_a) saw_abortado = 1'b1;
    if (abort_s && in_win) begin
      enb_hi  = cyc;
      done_at = cyc + 2;
      free_at = done_at;
      pend_q  = apply(start_q, cur_m, cur_d, cyc - enb_lo + 1);
      model_cnt = pend_q;
      abort_m = 1'b1;
    end
`endif
    if (done_a || done_b) last_done_cyc = cyc;
    last_rdy_a = a_ready;
    acc_a = era;
    acc_b = erb;
    if (acc_a || acc_b) begin
      own_b_m  = acc_b;
      prio_b_m = acc_a;
      cur_m    = acc_b ? b_modo : a_modo;
      cur_d    = acc_b ? b_dato : a_dato;
      cur_n    = int'(acc_b ? b_pasos : a_pasos);
      start_q  = model_cnt;
      pend_q   = apply(model_cnt, cur_m, cur_d, cur_n);
      model_cnt = pend_q;
      enb_lo   = cyc + 1;
      enb_hi   = cyc + cur_n;
      done_at  = cyc + cur_n + 2;
      free_at  = done_at;
      abort_m  = 1'b0;
      last_acc_cyc = cyc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit to_b, input logic [1:0] m, input logic [3:0] d,
                      input logic [PASOS_W-1:0] p);
    int k = 0;
    if (to_b) begin
      b_valid = 1'b1; b_modo = m; b_dato = d; b_pasos = p;
    end else begin
      a_valid = 1'b1; a_modo = m; a_dato = d; a_pasos = p;
    end
    do begin
      cycle();
      k++;
    end while (!(to_b ? acc_b : acc_a) && k < 300);
    if (!(to_b ? acc_b : acc_a)) check("send_timeout", 0, 1);
    if (to_b) b_valid = 1'b0;
    else a_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (cyc < free_at && k < 400) begin
      cycle();
      k++;
    end
  endtask

  // Both requesters raise VALID in the same cycle. first_b reports who won.
  task automatic pair(output bit first_b);
    bit got_a = 1'b0;
    bit got_b = 1'b0;
    int k = 0;
    first_b = 1'b0;
    a_valid = 1'b1; a_modo = 2'b00; a_dato = 4'd0; a_pasos = 8'd2;
    b_valid = 1'b1; b_modo = 2'b01; b_dato = 4'd0; b_pasos = 8'd3;
    while (!(got_a && got_b) && k < 300) begin
      cycle();
      k++;
      if (acc_b && !got_a) first_b = 1'b1;
      if (acc_a) begin got_a = 1'b1; a_valid = 1'b0; end
      if (acc_b) begin got_b = 1'b1; b_valid = 1'b0; end
    end
    if (!(got_a && got_b)) check("pair_timeout", 0, 1);
  endtask

  initial begin
    bit fb;
    int steps;
    rst = 1'b1;
    a_valid = 1'b0; a_modo = 2'b00; a_dato = 4'd0; a_pasos = '0;
    b_valid = 1'b0; b_modo = 2'b00; b_dato = 4'd0; b_pasos = '0;
    repeat (2) @(posedge clk);
    a_valid = 1'b1;
    #1;
    check("rst_ready_a", a_ready, 0);
    check("rst_enb", cnt_enb, 0);
    check("rst_modo", cnt_modo, 0);
    check("rst_d", cnt_d, 0);
    check("rst_done", {done_a, done_b}, 0);
    check("rst_qfinal", q_final, 0);
    check("rst_busy", busy, 0);
    a_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single load of 9.
    send(1'b0, 2'b11, 4'd9, 8'd1);
    drain();
    check("tp_load9", q_final, 9);
    check("tp_load9_lat", last_done_cyc - last_acc_cyc, 3);

    // Up 8 from 9 wraps to 1.
    send(1'b0, 2'b00, 4'd0, 8'd8);
    drain();
    check("tp_up8", q_final, 1);
    check("tp_up8_lat", last_done_cyc - last_acc_cyc, 10);

    // Load 2, then down-by-3 wraps to 15, then a zero-step command from B.
    send(1'b0, 2'b11, 4'd2, 8'd1);
    drain();
    send(1'b0, 2'b10, 4'd0, 8'd1);
    drain();
    check("tp_dn3", q_final, 15);
    send(1'b1, 2'b00, 4'd0, 8'd0);
    drain();
    check("tp_zero_q", q_final, 15);
    check("tp_zero_lat", last_done_cyc - last_acc_cyc, 2);
    check("tp_zero_owner", own_b_m, 1);

    // B was served last, so A wins the first tie. After a lone A, B wins the next tie.
    pair(fb);
    check("pair1_first_b", fb, 0);
    drain();
    send(1'b0, 2'b11, 4'd7, 8'd1);
    drain();
    pair(fb);
    check("pair2_first_b", fb, 1);
    drain();

    // Reset in the middle of a 20-step run.
    send(1'b0, 2'b00, 4'd0, 8'd20);
    repeat (4) cycle();
    #1;
    rst = 1'b1;
    #1;
    check("midrst_enb", cnt_enb, 0);
    check("midrst_busy", busy, 0);
    steps = cyc + 1 - enb_lo;
    if (steps > cur_n) steps = cur_n;
    model_cnt = apply(start_q, cur_m, cur_d, steps);
    free_at = 0; done_at = -1; enb_lo = 1; enb_hi = 0;
    prio_b_m = 1'b0; qf_exp = 4'd0; abort_m = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
    a_valid = 1'b1; a_modo = 2'b11; a_dato = 4'd5; a_pasos = 8'd1;
    cycle();
    check("midrst_ready_next", last_rdy_a, 1);
    a_valid = 1'b0;
    drain();
    check("midrst_reload", q_final, 5);

`ifdef CONTROLADOR_ABORT_EN
    // Up 10 from 0, with ABORT in the 4th RUN cycle.
    send(1'b0, 2'b11, 4'd0, 8'd1);
    drain();
    send(1'b0, 2'b00, 4'd0, 8'd10);
    repeat (3) cycle();
    abort_s = 1'b1;
    cycle();
    abort_s = 1'b0;
    drain();
    check("tp_abort_q", q_final, 4);
    check("tp_abort_flag", saw_abortado, 1);
`endif

    // Random traffic from both requesters, including withdrawn requests.
    for (int i = 0; i < 600; i++) begin
      cycle();
      if (acc_a) a_valid = 1'b0;
      else if (a_valid && $urandom_range(31) == 0) a_valid = 1'b0;
      else if (!a_valid && $urandom_range(3) == 0) begin
        a_valid = 1'b1;
        a_modo  = 2'($urandom_range(3));
        a_dato  = 4'($urandom_range(15));
        a_pasos = PASOS_W'($urandom_range(9));
      end
      if (acc_b) b_valid = 1'b0;
      else if (b_valid && $urandom_range(31) == 0) b_valid = 1'b0;
      else if (!b_valid && $urandom_range(3) == 0) begin
        b_valid = 1'b1;
        b_modo  = 2'($urandom_range(3));
        b_dato  = 4'($urandom_range(15));
        b_pasos = PASOS_W'($urandom_range(9));
      end
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    drain();
    cycle();
    check("final_counter", cnt_q, model_cnt);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
